vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-clock-domain VGA raster timing generator. Sits directly downstream of pll_clk and consumes its 25.175 MHz pixel clock and its lock indicator.
- Holds the raster idle until the PLL lock has been synchronized and has been stable for a settle window.
- Then produces hsync/vsync, an active-video flag, raster coordinates and line/frame strobes for the pixel pipeline.
- Drops back to idle whenever lock is lost.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)
- SETTLE_CYCLES, 1024, clocks lock must hold before the raster starts (≥1)

Ports:
- clk  input  1  pixel clock from pll_clk
- reset  input  1  asynchronous, active-high reset
- pll_locked  input  1  PLL lock indicator, treated as asynchronous
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- video_on  output  1  high while (pixel_x, pixel_y) is inside the active area
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse at pixel_x==0 while running
- frame_start  output  1  one-cycle pulse at pixel_x==0 && pixel_y==0 while running
- running  output  1  high in RUN state

Behaviour:
- Interface fixed: one clock, clk. Reset is asynchronous and active-high, named reset.
- Totals:
  - H_TOTAL = sum of the H_* parameters (default 800).
  - V_TOTAL = sum of the V_* parameters (default 525).
  - Both must be ≤1024; an elaboration-time assertion enforces this.
- Reset values:
  - State WAIT_LOCK; both synchronizer flops 0; settle counter 0; h/v counters 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - video_on, line_start, frame_start and running are all 0.
- Lock sync:
  - pll_locked passes through a 2-flop synchronizer to produce lock_s.
  - No other logic samples pll_locked directly.
- FSM:
  - WAIT_LOCK: counters held at 0, outputs idle. When lock_s == 1, go to SETTLE with settle_cnt = 0.
  - SETTLE: settle_cnt increments each clock. If lock_s == 0, go to WAIT_LOCK. If settle_cnt == SETTLE_CYCLES-1, go to RUN with h = 0, v = 0.
  - RUN: raster counting. If lock_s == 0, go to WAIT_LOCK on the next edge; counters clear to 0 and all outputs return to idle values on that same edge.
  - If lock loss coincides with a wrap or any strobe, lock loss wins.
- Counters (RUN only):
  - h increments every clock; at H_TOTAL-1 it wraps to 0.
  - v increments only on an h wrap; at V_TOTAL-1 (with h wrap) it wraps to 0.
- Output alignment: every output is a flop loaded from the decode of the counter values being loaded on the same edge. Outputs are therefore exactly aligned with pixel_x/pixel_y, with no extra latency.
- Decode (RUN only):
  - video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync asserted (= HSYNC_POL) for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
  - vsync asserted (= VSYNC_POL) for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491 by default), for entire lines.
  - line_start = (h == 0). frame_start = (h == 0 && v == 0).
  - The first RUN cycle therefore pulses both line_start and frame_start.
- Startup latency: from the first edge sampling pll_locked = 1, running rises after 2 + 1 + SETTLE_CYCLES edges, i.e. 7 edges for SETTLE_CYCLES = 4.
- Glitch in SETTLE: a lock dropout of ≥1 synchronized cycle restarts the settle count from 0 after re-lock.
- Reset asserted in any state: immediate return to reset values (asynchronous). Deassertion is synchronous to clk through the team's reset-release flop.

Test Plan:
1. Reset asserted, pll_locked = 1 → hsync = 1, vsync = 1, video_on = 0, running = 0, pixel_x = pixel_y = 0 throughout reset.
2. SETTLE_CYCLES = 4; release reset, raise pll_locked → running rises on the 7th edge. The same cycle shows frame_start = 1, line_start = 1, pixel_x = 0, pixel_y = 0, video_on = 1.
3. Default params, run 2 full frames → frame_start period is exactly 420000 clocks and line_start period is 800.
   - hsync is low for exactly 96 clocks, at pixel_x 656..751.
   - vsync is low for exactly 1600 clocks, at lines 490..491.
   - video_on is high for exactly 307200 clocks per frame.
4. Wrap boundary: at pixel_x = 799, pixel_y = 524 → next clock gives pixel_x = 0, pixel_y = 0, frame_start = 1. At pixel_x = 639 → next clock video_on = 0.
5. Drop pll_locked at pixel_x = 700, pixel_y = 100 → two edges later (synchronizer) state is WAIT_LOCK on the following edge. Then hsync = 1, vsync = 1, pixel_x = pixel_y = 0, running = 0. Re-lock gives a full settle window before frame_start.
6. SETTLE_CYCLES = 8; pulse pll_locked low for 3 clocks during SETTLE → settle restarts. running rises 8 clocks after lock_s returns high plus 1 edge. HSYNC_POL = 1 variant: hsync idle level is 0 and it is high during 656..751.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel pipeline.
// The master drives the bundle and the slave samples it.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;
  logic       running;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, running
  );
  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, running
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It waits for a synchronized and settled PLL lock,
// then produces registered sync, active-video, coordinate and strobe outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_check
    $error("vga_timing_gen: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t          state, state_nxt;
  logic   [SW-1:0] settle_cnt, settle_nxt;
  logic   [9:0]    h_nxt, v_nxt;
  logic            rst_q;
  logic   [1:0]    lock_sync;
  logic            lock_s;
  logic            run_nxt;

  // Reset asserts immediately but releases on a clock edge, so no flop below
  // ever sees a reset deassertion that is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 1'b1;
    else       rst_q <= 1'b0;
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values; blocking
  // assignments here would make the synchronizer collapse into one stage.
  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) lock_sync <= 2'b00;
    else       lock_sync <= {lock_sync[0], pll_locked};
  end
  assign lock_s = lock_sync[1];

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred. Idle counters default to zero.
  always_comb begin
    state_nxt  = state;
    settle_nxt = '0;
    h_nxt      = '0;
    v_nxt      = '0;
    unique case (state)
      WAIT_LOCK: if (lock_s) state_nxt = SETTLE;
      SETTLE: begin
        if (!lock_s)                       state_nxt  = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
        else                               settle_nxt = settle_cnt + 1'b1;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (vga.pixel_x == H_LAST) begin
          v_nxt = (vga.pixel_y == V_LAST) ? '0 : vga.pixel_y + 1'b1;
        end else begin
          h_nxt = vga.pixel_x + 1'b1;
          v_nxt = vga.pixel_y;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign run_nxt = (state_nxt == RUN);

  // Outputs decode the counter values being loaded, keeping them aligned with pixel_x/pixel_y.
  // NOTE: only control/datapath flops here, no memories, so all take the async reset.
  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      vga.pixel_x     <= '0;
      vga.pixel_y     <= '0;
      vga.hsync       <= ~HSYNC_POL;
      vga.vsync       <= ~VSYNC_POL;
      vga.video_on    <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.running     <= 1'b0;
    end else begin
      vga.pixel_x     <= h_nxt;
      vga.pixel_y     <= v_nxt;
      vga.hsync       <= (run_nxt && {1'b0, h_nxt} >= HS_BEG && {1'b0, h_nxt} < HS_END)
                         ? HSYNC_POL : ~HSYNC_POL;
      vga.vsync       <= (run_nxt && {1'b0, v_nxt} >= VS_BEG && {1'b0, v_nxt} < VS_END)
                         ? VSYNC_POL : ~VSYNC_POL;
      vga.video_on    <= run_nxt && ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
      vga.line_start  <= run_nxt && (h_nxt == '0);
      vga.frame_start <= run_nxt && (h_nxt == '0) && (v_nxt == '0);
      vga.running     <= run_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default raster, a small raster for
// whole-frame and lock-loss behaviour, and a slow-settle active-high-hsync variant.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lock_a = 1'b1;
  logic lock_b = 1'b1;
  logic lock_c = 1'b1;

  int checks = 0;
  int errors = 0;

  int hs_low, hs_min, hs_max, vs_low, vs_min, vs_max;
  int vo_cnt, ls_cnt, ls_first, ls_last, fs_cnt, fs_first, fs_last, early;

  always #5 clk = ~clk;

  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();
  vga_timing_gen_if ic ();

  vga_timing_gen #(.SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .pll_locked(lock_a), .vga(ia.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SETTLE_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset(reset), .pll_locked(lock_b), .vga(ib.master)
  );

  vga_timing_gen #(.SETTLE_CYCLES(8), .HSYNC_POL(1'b1)) dut_c (
    .clk(clk), .reset(reset), .pll_locked(lock_c), .vga(ic.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tally();
    hs_low = 0; hs_min = 1023; hs_max = 0;
    vs_low = 0; vs_min = 1023; vs_max = 0;
    vo_cnt = 0; ls_cnt = 0; ls_first = 0; ls_last = 0;
    fs_cnt = 0; fs_first = 0; fs_last = 0;
  endtask

  initial begin
    // Reset held with lock asserted: everything idle.
    for (int i = 0; i < 3; i++) tick();
    check("rst_a_hsync",   ia.hsync, 1);
    check("rst_a_vsync",   ia.vsync, 1);
    check("rst_a_video",   ia.video_on, 0);
    check("rst_a_running", ia.running, 0);
    check("rst_a_x",       ia.pixel_x, 0);
    check("rst_a_y",       ia.pixel_y, 0);
    check("rst_a_strobes", {ia.line_start, ia.frame_start}, 0);
    check("rst_c_hsync",   ic.hsync, 0);
    check("rst_c_vsync",   ic.vsync, 1);

    lock_a = 1'b0; lock_b = 1'b0; lock_c = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("idle_a_running", ia.running, 0);

    // Startup latency: running on the 7th edge with both strobes.
    lock_a = 1'b1;
    early = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ia.running) early++;
    end
    check("a_early_running", early, 0);
    tick();
    check("a_start_running", ia.running, 1);
    check("a_start_frame",   ia.frame_start, 1);
    check("a_start_line",    ia.line_start, 1);
    check("a_start_x",       ia.pixel_x, 0);
    check("a_start_y",       ia.pixel_y, 0);
    check("a_start_video",   ia.video_on, 1);
    check("a_start_hsync",   ia.hsync, 1);

    // Two full default lines.
    clear_tally();
    for (int i = 1; i <= 1600; i++) begin
      tick();
      if (!ia.hsync) begin
        hs_low++;
        if (int'(ia.pixel_x) < hs_min) hs_min = int'(ia.pixel_x);
        if (int'(ia.pixel_x) > hs_max) hs_max = int'(ia.pixel_x);
      end
      if (!ia.vsync)     vs_low++;
      if (ia.video_on)   vo_cnt++;
      if (ia.frame_start) fs_cnt++;
      if (ia.line_start) begin
        ls_cnt++;
        if (ls_cnt == 1) ls_first = i;
        ls_last = i;
      end
    end
    check("a_hsync_low_cnt", hs_low, 192);
    check("a_hsync_first_x", hs_min, 656);
    check("a_hsync_last_x",  hs_max, 751);
    check("a_vsync_low_cnt", vs_low, 0);
    check("a_video_cnt",     vo_cnt, 1280);
    check("a_frame_cnt",     fs_cnt, 0);
    check("a_line_cnt",      ls_cnt, 2);
    check("a_line_first",    ls_first, 800);
    check("a_line_period",   ls_last - ls_first, 800);
    check("a_pos_x",         ia.pixel_x, 0);
    check("a_pos_y",         ia.pixel_y, 2);

    // Active-area right edge.
    for (int i = 0; i < 639; i++) tick();
    check("a_x639",       ia.pixel_x, 639);
    check("a_x639_video", ia.video_on, 1);
    tick();
    check("a_x640",       ia.pixel_x, 640);
    check("a_x640_video", ia.video_on, 0);

    // Small raster: 16 x 10, hsync at x 10..12, vsync on lines 7..8.
    check("b_idle_running", ib.running, 0);
    lock_b = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("b_start_running", ib.running, 1);
    check("b_start_frame",   ib.frame_start, 1);

    clear_tally();
    for (int i = 1; i <= 320; i++) begin
      tick();
      if (!ib.hsync) begin
        hs_low++;
        if (int'(ib.pixel_x) < hs_min) hs_min = int'(ib.pixel_x);
        if (int'(ib.pixel_x) > hs_max) hs_max = int'(ib.pixel_x);
      end
      if (!ib.vsync) begin
        vs_low++;
        if (int'(ib.pixel_y) < vs_min) vs_min = int'(ib.pixel_y);
        if (int'(ib.pixel_y) > vs_max) vs_max = int'(ib.pixel_y);
      end
      if (ib.video_on)   vo_cnt++;
      if (ib.line_start) ls_cnt++;
      if (ib.frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = i;
        fs_last = i;
      end
    end
    check("b_frame_cnt",     fs_cnt, 2);
    check("b_frame_first",   fs_first, 160);
    check("b_frame_period",  fs_last - fs_first, 160);
    check("b_line_cnt",      ls_cnt, 20);
    check("b_hsync_low_cnt", hs_low, 60);
    check("b_hsync_first_x", hs_min, 10);
    check("b_hsync_last_x",  hs_max, 12);
    check("b_vsync_low_cnt", vs_low, 64);
    check("b_vsync_first_y", vs_min, 7);
    check("b_vsync_last_y",  vs_max, 8);
    check("b_video_cnt",     vo_cnt, 96);

    // Frame wrap boundary.
    for (int i = 0; i < 159; i++) tick();
    check("b_last_x",     ib.pixel_x, 15);
    check("b_last_y",     ib.pixel_y, 9);
    check("b_last_frame", ib.frame_start, 0);
    tick();
    check("b_wrap_x",     ib.pixel_x, 0);
    check("b_wrap_y",     ib.pixel_y, 0);
    check("b_wrap_frame", ib.frame_start, 1);

    // Lock loss at (8,7): two more raster edges, then idle.
    for (int i = 0; i < 120; i++) tick();
    check("b_drop_x", ib.pixel_x, 8);
    check("b_drop_y", ib.pixel_y, 7);
    lock_b = 1'b0;
    tick();
    check("b_drop1_x", ib.pixel_x, 9);
    tick();
    check("b_drop2_x",     ib.pixel_x, 10);
    check("b_drop2_hsync", ib.hsync, 0);
    check("b_drop2_run",   ib.running, 1);
    tick();
    check("b_idle_running", ib.running, 0);
    check("b_idle_hsync",   ib.hsync, 1);
    check("b_idle_vsync",   ib.vsync, 1);
    check("b_idle_x",       ib.pixel_x, 0);
    check("b_idle_y",       ib.pixel_y, 0);
    check("b_idle_video",   ib.video_on, 0);
    tick();
    lock_b = 1'b1;
    early = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ib.running) early++;
    end
    check("b_relock_early", early, 0);
    tick();
    check("b_relock_running", ib.running, 1);
    check("b_relock_frame",   ib.frame_start, 1);

    // Slow settle with a dropout three edges after lock rises.
    lock_c = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("c_settle_hsync", ic.hsync, 0);
    lock_c = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    lock_c = 1'b1;
    early = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (ic.running) early++;
    end
    check("c_glitch_early", early, 0);
    tick();
    check("c_start_running", ic.running, 1);
    check("c_start_frame",   ic.frame_start, 1);

    // Active-high hsync window 656..751.
    for (int i = 0; i < 655; i++) tick();
    check("c_x655",       ic.pixel_x, 655);
    check("c_x655_hsync", ic.hsync, 0);
    tick();
    check("c_x656_hsync", ic.hsync, 1);
    for (int i = 0; i < 95; i++) tick();
    check("c_x751",       ic.pixel_x, 751);
    check("c_x751_hsync", ic.hsync, 1);
    tick();
    check("c_x752_hsync", ic.hsync, 0);

    // Reset clears a running raster without waiting for an edge.
    check("a_pre_reset_running", ia.running, 1);
    reset = 1'b1;
    #1;
    check("areset_a_running", ia.running, 0);
    check("areset_a_x",       ia.pixel_x, 0);
    check("areset_a_hsync",   ia.hsync, 1);
    check("areset_c_hsync",   ic.hsync, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
